// File: rtl/coin_acceptor_pkg.sv
// Shared coin encodings and default timing/queue sizes for the coin acceptor.
// No logic; imported by every coin_acceptor file.
package coin_acceptor_pkg;

    typedef enum logic {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int FIFO_DEPTH_DEF      = 4;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus counter debouncer; rise pulses on a debounced 0->1 flip.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples; no backpressure (free-running).
module coin_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic sense,
    output logic rise
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sense;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise    = 1'b0;
        // The counter only runs while the synchronised line disagrees with the accepted level.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise    = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounced coin sensors feeding a small coin queue; releases one nickel/dime pulse per cycle.
// Latency DEBOUNCE_CYCLES+2 from raw rise; hold stalls release, a full queue drops coins with coin_reject.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 5,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int PTR_W           = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             nickel_sense,
    input  logic             dime_sense,
    input  logic             hold,
    output logic             nickel_in,
    output logic             dime_in,
    output logic             coin_reject,
    output logic [PTR_W:0]   coin_count
);

    logic             nickel_rise, dime_rise;
    coin_e            mem_q [FIFO_DEPTH];
    coin_e            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] dime_slot;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   free_slots;
    logic             reject_q, reject_d;
    logic             pop, nickel_push, dime_push;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_nickel_db (
        .clock (clock),
        .reset (reset),
        .sense (nickel_sense),
        .rise  (nickel_rise)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dime_db (
        .clock (clock),
        .reset (reset),
        .sense (dime_sense),
        .rise  (dime_rise)
    );

    always_comb begin
        pop       = (count_q != '0) && !hold;
        nickel_in = pop && (mem_q[rd_ptr_q] == COIN_NICKEL);
        dime_in   = pop && (mem_q[rd_ptr_q] == COIN_DIME);

        // A slot freed by this cycle's pop is reusable at the same edge.
        free_slots  = (PTR_W+1)'(FIFO_DEPTH) - count_q + (PTR_W+1)'(pop);
        nickel_push = nickel_rise && (free_slots != '0);
        dime_push   = dime_rise && (nickel_push ? (free_slots >= (PTR_W+1)'(2))
                                                : (free_slots != '0));

        mem_d     = mem_q;
        dime_slot = wr_ptr_q + PTR_W'(nickel_push);
        if (nickel_push) mem_d[wr_ptr_q] = COIN_NICKEL;
        if (dime_push)   mem_d[dime_slot] = COIN_DIME;

        wr_ptr_d = wr_ptr_q + PTR_W'(nickel_push) + PTR_W'(dime_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(nickel_push) + (PTR_W+1)'(dime_push)
                           - (PTR_W+1)'(pop);
        reject_d = (nickel_rise && !nickel_push) || (dime_rise && !dime_push);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: COIN_NICKEL};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    assign coin_reject = reject_q;
    assign coin_count  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random bouncy sensors vs a window/queue model.
module tb_coin_acceptor;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_sense, dime_sense, hold;
    logic       nickel_in, dime_in, coin_reject;
    logic [2:0] coin_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .FIFO_DEPTH      (DEPTH),
        .PTR_W           (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .nickel_sense (nickel_sense),
        .dime_sense   (dime_sense),
        .hold         (hold),
        .nickel_in    (nickel_in),
        .dime_in      (dime_in),
        .coin_reject  (coin_reject),
        .coin_count   (coin_count)
    );

    // Reference model: raw sample history, synchronised-value window, coin queue.
    bit raw_n[$];
    bit raw_d[$];
    bit syn_n[$];
    bit syn_d[$];
    bit lvl_n, lvl_d;
    bit mq[$];
    bit m_rej;

    function automatic bit window_flips(input bit s[$], input bit lvl);
        if (s.size() < D) return 1'b0;
        for (int i = 0; i < D; i++)
            if (s[s.size()-1-i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_n();
        return (mq.size() > 0) && !hold && (mq[0] == 1'b0);
    endfunction

    function automatic bit exp_d();
        return (mq.size() > 0) && !hold && (mq[0] == 1'b1);
    endfunction

    function automatic logic [2:0] exp_cnt();
        return 3'(mq.size());
    endfunction

    // Advances the model over the rising edge that just happened, using the inputs held across it.
    task automatic model_step();
        bit rise_n, rise_d;
        if (reset) begin
            raw_n = '{0, 0, 0};
            raw_d = '{0, 0, 0};
            syn_n.delete();
            syn_d.delete();
            lvl_n = 1'b0;
            lvl_d = 1'b0;
            mq.delete();
            m_rej = 1'b0;
        end else begin
            raw_n.push_back(nickel_sense);
            raw_d.push_back(dime_sense);
            syn_n.push_back(raw_n[raw_n.size()-3]);
            syn_d.push_back(raw_d[raw_d.size()-3]);
            while (raw_n.size() > 4) void'(raw_n.pop_front());
            while (raw_d.size() > 4) void'(raw_d.pop_front());
            while (syn_n.size() > D) void'(syn_n.pop_front());
            while (syn_d.size() > D) void'(syn_d.pop_front());
            rise_n = 1'b0;
            rise_d = 1'b0;
            if (window_flips(syn_n, lvl_n)) begin
                rise_n = !lvl_n;
                lvl_n  = !lvl_n;
            end
            if (window_flips(syn_d, lvl_d)) begin
                rise_d = !lvl_d;
                lvl_d  = !lvl_d;
            end
            if (mq.size() > 0 && !hold) void'(mq.pop_front());
            m_rej = 1'b0;
            if (rise_n) begin
                if (mq.size() < DEPTH) mq.push_back(1'b0);
                else m_rej = 1'b1;
            end
            if (rise_d) begin
                if (mq.size() < DEPTH) mq.push_back(1'b1);
                else m_rej = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit n, input bit d, input bit h);
        @(negedge clock);
        model_step();
        reset        = r;
        nickel_sense = n;
        dime_sense   = d;
        hold         = h;
        #1;
    endtask

    task automatic quiet(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; nickel_sense = 1'b0; dime_sense = 1'b0; hold = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({nickel_in, dime_in, coin_reject, coin_count} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got n=%b d=%b rej=%b cnt=%0d, want all 0",
                     nickel_in, dime_in, coin_reject, coin_count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        quiet(4);
    endtask

    task automatic test_single_nickel();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (nickel_in !== (i == 6) || dime_in !== 1'b0) begin
                errors++;
                $display("FAIL single_nickel cyc %0d: got n=%b d=%b, want n=%b d=0",
                         i, nickel_in, dime_in, (i == 6));
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (coin_count !== ((i == 6) ? 3'd1 : 3'd0)) begin
                    errors++;
                    $display("FAIL single_nickel_count cyc %0d: got %0d want %0d",
                             i, coin_count, (i == 6) ? 1 : 0);
                end
            end
        end
        quiet(D + 4);
    endtask

    task automatic test_glitch();
        bit pattern [12] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, pattern[i], 1'b0, 1'b0);
            checks++;
            if (nickel_in !== 1'b0 || coin_count !== 3'd0 ||
                coin_count !== exp_cnt()) begin
                errors++;
                $display("FAIL glitch cyc %0d: got n=%b cnt=%0d, want n=0 cnt=0 (model %0d)",
                         i, nickel_in, coin_count, exp_cnt());
            end
        end
        quiet(D + 4);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (nickel_in !== (i == 6) || dime_in !== (i == 7)) begin
                errors++;
                $display("FAIL simultaneous cyc %0d: got n=%b d=%b, want n=%b d=%b",
                         i, nickel_in, dime_in, (i == 6), (i == 7));
            end
        end
        quiet(D + 4);
    endtask

    task automatic test_hold_full();
        int max_cnt = 0;
        int rejects = 0;
        for (int e = 0; e < 5; e++) begin
            for (int i = 0; i < 13; i++) begin
                drive(1'b0, (i < 6), 1'b0, 1'b1);
                if (coin_reject === 1'b1) rejects++;
                if (int'(coin_count) > max_cnt) max_cnt = int'(coin_count);
                checks++;
                if ({nickel_in, dime_in, coin_reject, coin_count} !==
                    {exp_n(), exp_d(), m_rej, exp_cnt()}) begin
                    errors++;
                    $display("FAIL hold_full ev %0d cyc %0d: got n=%b d=%b rej=%b cnt=%0d want n=%b d=%b rej=%b cnt=%0d",
                             e, i, nickel_in, dime_in, coin_reject, coin_count,
                             exp_n(), exp_d(), m_rej, exp_cnt());
                end
            end
        end
        checks++;
        if (max_cnt != DEPTH || rejects != 1) begin
            errors++;
            $display("FAIL hold_full_summary: got max_cnt=%0d rejects=%0d want %0d and 1",
                     max_cnt, rejects, DEPTH);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (nickel_in !== (i < 4) || dime_in !== 1'b0) begin
                errors++;
                $display("FAIL hold_release cyc %0d: got n=%b d=%b want n=%b d=0",
                         i, nickel_in, dime_in, (i < 4));
            end
        end
        quiet(D + 4);
    endtask

    task automatic test_full_pop_push();
        bit rel[$];
        bit want[$] = '{0, 0, 0, 0, 1};
        for (int e = 0; e < 4; e++)
            for (int i = 0; i < 13; i++) drive(1'b0, (i < 6), 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, (i < 8), (i < 5));
            if (nickel_in === 1'b1) rel.push_back(1'b0);
            if (dime_in === 1'b1) rel.push_back(1'b1);
            checks++;
            if (coin_reject !== 1'b0 || (i == 6 && coin_count !== 3'd4)) begin
                errors++;
                $display("FAIL full_pop_push cyc %0d: got rej=%b cnt=%0d want rej=0 cnt=4 at cyc 6",
                         i, coin_reject, coin_count);
            end
        end
        checks++;
        if (rel != want) begin
            errors++;
            $display("FAIL full_pop_push_order: got %0d releases %p want %p", rel.size(), rel, want);
        end
        quiet(D + 4);
    endtask

    task automatic test_reset_mid();
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < 13; i++) drive(1'b0, (i < 6), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (i == 0 && {nickel_in, dime_in, coin_reject, coin_count} !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid_clear: got n=%b d=%b rej=%b cnt=%0d want all 0",
                         nickel_in, dime_in, coin_reject, coin_count);
            end else if (i > 0 && (dime_in !== (i == 6) || nickel_in !== 1'b0)) begin
                errors++;
                $display("FAIL reset_mid_coin cyc %0d: got n=%b d=%b want n=0 d=%b",
                         i, nickel_in, dime_in, (i == 6));
            end
        end
        quiet(D + 4);
    endtask

    task automatic test_random();
        bit n = 1'b0;
        bit d = 1'b0;
        bit h;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) n = !n;
            if ($urandom_range(0, 4) == 0) d = !d;
            h = ($urandom_range(0, 3) == 0);
            drive(1'b0, n, d, h);
            checks++;
            if ({nickel_in, dime_in, coin_reject, coin_count} !==
                {exp_n(), exp_d(), m_rej, exp_cnt()} || (nickel_in && dime_in)) begin
                errors++;
                $display("FAIL random cyc %0d: got n=%b d=%b rej=%b cnt=%0d want n=%b d=%b rej=%b cnt=%0d",
                         i, nickel_in, dime_in, coin_reject, coin_count,
                         exp_n(), exp_d(), m_rej, exp_cnt());
            end
        end
        quiet(D + 8);
        checks++;
        if (coin_count !== 3'd0 || coin_count !== exp_cnt()) begin
            errors++;
            $display("FAIL random_drain: got cnt=%0d want 0 (model %0d)", coin_count, exp_cnt());
        end
    endtask

    initial begin
        test_reset();
        test_single_nickel();
        test_glitch();
        test_simultaneous();
        test_hold_full();
        test_full_pop_push();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
